// File: rtl/dip_pkg.sv
// Shared types for the DIP frame filter: frame layout and settle FSM states.
package dip_pkg;

    localparam int unsigned DIP_DATA_W = 16;
    localparam int unsigned DIP_SW_W   = 5;

    // Switch bits sit above the data word so {frame_sw, frame_data} maps directly.
    typedef struct packed {
        logic [DIP_SW_W-1:0]   sw;
        logic [DIP_DATA_W-1:0] data;
    } dip_frame_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } dip_state_t;

endpackage

// File: rtl/dip_frame_watchdog.sv
// Stall detector for the DIP reader: counts cycles since the last frame event
// and raises stale once TIMEOUT_CYCLES elapse without one.
module dip_frame_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic event_i,
    output logic stale_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stale_q, stale_d;

    // Next-state: an event always wins over saturation in the same cycle.
    always_comb begin
        cnt_d   = cnt_q;
        stale_d = stale_q;
        if (event_i) begin
            cnt_d   = '0;
            stale_d = 1'b0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == LIMIT) begin
                stale_d = 1'b1;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end

    assign stale_o = stale_q;

endmodule

// File: rtl/dip_frame_filter.sv
// Debounces frames from the DIP serial reader: a value is committed only after
// STABLE_FRAMES consecutive identical frames. Optional watchdog is built when
// DIP_FILTER_WATCHDOG_EN is defined; otherwise stale is tied low.
module dip_frame_filter
    import dip_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIP_DATA_W-1:0] frame_data,
    input  logic [DIP_SW_W-1:0]   frame_sw,
    input  logic                  frame_latch,
    output logic [DIP_DATA_W-1:0] out_data,
    output logic [DIP_SW_W-1:0]   out_sw,
    output logic                  out_valid,
    output logic                  out_changed,
    output logic                  have_value,
    output logic                  stale
);

    localparam int unsigned CNT_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_FRAMES);
    localparam bit SINGLE = (STABLE_FRAMES == 1);

    logic          latch_q;
    logic          frame_ev;
    dip_frame_t    frame_in;

    dip_state_t    state_q, state_d;
    dip_frame_t    cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dip_frame_t    out_q, out_d;
    logic          valid_q, valid_d;
    logic          changed_q, changed_d;
    logic          have_q, have_d;
    logic          commit;

    assign frame_ev = latch_q & ~frame_latch;
    assign frame_in = {frame_sw, frame_data};

    // Falling-edge detector on the reader latch; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= 1'b1;
        end else begin
            latch_q <= frame_latch;
        end
    end

    // Settle FSM next-state and commit decision. A commit always takes the
    // incoming frame, which equals the candidate whenever a commit happens.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        if (frame_ev) begin
            case (state_q)
                EMPTY, LOCKED: begin
                    if (state_q == EMPTY || frame_in != out_q) begin
                        cand_d = frame_in;
                        cnt_d  = CNT_ONE;
                        if (SINGLE) begin
                            commit  = 1'b1;
                            state_d = LOCKED;
                        end else begin
                            state_d = SETTLING;
                        end
                    end
                end
                SETTLING: begin
                    if (frame_in == cand_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CNT_STABLE) begin
                            commit  = 1'b1;
                            state_d = LOCKED;
                        end
                    end else begin
                        cand_d = frame_in;
                        cnt_d  = CNT_ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output next-state: committed value, pulses and have_value.
    always_comb begin
        out_d     = commit ? frame_in : out_q;
        valid_d   = commit;
        changed_d = commit && (!have_q || frame_in != out_q);
        have_d    = have_q | commit;
    end

    // State, candidate and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            cand_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            have_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            have_q    <= have_d;
        end
    end

    assign out_data    = out_q.data;
    assign out_sw      = out_q.sw;
    assign out_valid   = valid_q;
    assign out_changed = changed_q;
    assign have_value  = have_q;

`ifdef DIP_FILTER_WATCHDOG_EN
    dip_frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .event_i (frame_ev),
        .stale_o (stale)
    );
`else
    // Timeout is meaningless without the watchdog; consumed here only to keep
    // the parameter interface identical between builds.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_dip_frame_filter.sv
// Scoreboard bench for dip_frame_filter: stimulus pushes expected commits from
// a run-length reference model; a negedge monitor pops and compares.
module tb_dip_frame_filter;

    localparam int unsigned STABLE  = 3;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_data;
    logic [4:0]  frame_sw;
    logic        frame_latch;
    logic [15:0] out_data;
    logic [4:0]  out_sw;
    logic        out_valid;
    logic        out_changed;
    logic        have_value;
    logic        stale;

    dip_frame_filter #(
        .STABLE_FRAMES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_data  (frame_data),
        .frame_sw    (frame_sw),
        .frame_latch (frame_latch),
        .out_data    (out_data),
        .out_sw      (out_sw),
        .out_valid   (out_valid),
        .out_changed (out_changed),
        .have_value  (have_value),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  sw;
        logic        changed;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int tests = 0;
    int fails = 0;

    // Reference model: a commit happens exactly when the current run of
    // identical frames reaches STABLE in length.
    logic [20:0] run_val = '0;
    int          run_len = 0;
    logic [20:0] m_comm  = '0;
    bit          m_have  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        run_val = '0;
        run_len = 0;
        m_comm  = '0;
        m_have  = 1'b0;
        expq.delete();
    endtask

    task automatic model_event(input logic [20:0] f, input int at_cyc);
        exp_t e;
        if (run_len > 0 && f == run_val) run_len++;
        else begin
            run_val = f;
            run_len = 1;
        end
        if (run_len == STABLE) begin
            e.data    = f[15:0];
            e.sw      = f[20:16];
            e.changed = !m_have || (f != m_comm);
            e.cyc     = at_cyc;
            expq.push_back(e);
            m_comm = f;
            m_have = 1'b1;
        end
    endtask

    // Latch low for 'hold' cycles (one event), then idle 'gap' cycles with
    // garbage on the data lines that must be ignored.
    task automatic send_frame(input logic [15:0] d, input logic [4:0] s, input int hold, input int gap);
        @(negedge clk);
        frame_data  = d;
        frame_sw    = s;
        frame_latch = 1'b0;
        model_event({s, d}, cyc + 1);
        repeat (hold) @(negedge clk);
        frame_latch = 1'b1;
        frame_data  = 16'($urandom);
        frame_sw    = 5'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: pops expected commits when the DUT pulses, checks holds otherwise.
    initial begin : monitor
        exp_t e;
        logic [15:0] hd;
        logic [4:0]  hs;
        logic        hh;
        hd = '0; hs = '0; hh = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hd = '0; hs = '0; hh = 1'b0;
            end else begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    check("late_commit_missing", 32'd0, 32'd1);
                end
                if (out_valid) begin
                    if (expq.size() > 0 && expq[0].cyc == cyc) begin
                        e = expq.pop_front();
                        check("commit_data", 32'(out_data), 32'(e.data));
                        check("commit_sw", 32'(out_sw), 32'(e.sw));
                        check("commit_changed", 32'(out_changed), 32'(e.changed));
                        check("commit_have", 32'(have_value), 32'd1);
                        hd = e.data; hs = e.sw; hh = 1'b1;
                    end else begin
                        check("unexpected_valid", 32'(out_valid), 32'd0);
                    end
                end else begin
                    if (expq.size() > 0 && expq[0].cyc == cyc) begin
                        e = expq.pop_front();
                        check("commit_missing", 32'(out_valid), 32'd1);
                    end
                    check("changed_without_valid", 32'(out_changed), 32'd0);
                end
                check("hold_data", 32'(out_data), 32'(hd));
                check("hold_sw", 32'(out_sw), 32'(hs));
                check("hold_have", 32'(have_value), 32'(hh));
`ifndef DIP_FILTER_WATCHDOG_EN
                check("stale_tied_low", 32'(stale), 32'd0);
`endif
            end
        end
    end

    initial begin : stimulus
        logic [15:0] pd[3];
        logic [4:0]  ps[3];
        int k;
        rst = 1'b1;
        frame_latch = 1'b1;
        frame_data = '0;
        frame_sw = '0;
        repeat (3) @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sw", 32'(out_sw), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_changed", 32'(out_changed), 32'd0);
        check("rst_have_value", 32'(have_value), 32'd0);
        check("rst_stale", 32'(stale), 32'd0);
        rst = 1'b0;

        // First commit after three identical frames.
        repeat (3) send_frame(16'hA5C3, 5'h11, 1, 24);
        check("first_commit_data", 32'(out_data), 32'hA5C3);
        check("first_commit_sw", 32'(out_sw), 32'h11);
        check("first_commit_have", 32'(have_value), 32'd1);

        // Interrupted run that re-establishes the same value.
        send_frame(16'hA5C3, 5'h11, 1, 24);
        send_frame(16'h1234, 5'h11, 1, 24);
        repeat (3) send_frame(16'hA5C3, 5'h11, 1, 24);

        // Alternating frames never settle.
        for (int i = 0; i < 10; i++) send_frame((i % 2 == 0) ? 16'h0001 : 16'h0002, 5'h00, 1, 5);

        // Long latch-low counts as one event: commit only on the third event.
        send_frame(16'h0BEE, 5'h1F, 5, 6);
        repeat (2) send_frame(16'h0BEE, 5'h1F, 1, 6);

`ifdef DIP_FILTER_WATCHDOG_EN
        send_frame(16'h0BEE, 5'h1F, 1, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("stale_before_timeout", 32'(stale), 32'd0);
        @(negedge clk);
        check("stale_at_timeout", 32'(stale), 32'd1);
        repeat (5) @(negedge clk);
        check("stale_holds", 32'(stale), 32'd1);
        send_frame(16'h0BEE, 5'h1F, 1, 0);
        check("stale_cleared", 32'(stale), 32'd0);
`endif

        // Reset in the middle of settling discards the partial candidate.
        repeat (2) send_frame(16'h7777, 5'h05, 1, 6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_sw", 32'(out_sw), 32'd0);
        check("async_rst_have", 32'(have_value), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) send_frame(16'h7777, 5'h05, 1, 6);
        check("post_rst_commit_data", 32'(out_data), 32'h7777);

        // Randomised runs over a small pool of values.
        for (int i = 0; i < 3; i++) begin
            pd[i] = 16'($urandom);
            ps[i] = 5'($urandom);
        end
        k = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 3) k = int'($urandom_range(0, 2));
            send_frame(pd[k], ps[k], int'($urandom_range(1, 3)), int'($urandom_range(1, 8)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
